// File: rtl/thr_intr_pkg.sv
// rtl/thr_intr_pkg.sv - shared encodings for the thread interrupt scheduler
package thr_intr_pkg;

    typedef enum logic [1:0] {
        REQ_NUKE   = 2'd0,
        REQ_RESUME = 2'd1,
        REQ_RESET  = 2'd2,
        REQ_RSVD   = 2'd3
    } req_type_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_GAP   = 2'd3
    } sched_state_e;

    // Thread-FSM "dead" encoding used by the ifu thread state machine
    localparam logic [4:0] THR_DEAD = 5'b00000;

    // A nuke retires once the thread is dead; resume/reset once it has left dead
    function automatic logic req_done(req_type_e t, logic [4:0] st);
        return (t == REQ_NUKE) ? (st == THR_DEAD) : (st != THR_DEAD);
    endfunction

endpackage

// File: rtl/thr_intr_sched_if.sv
// rtl/thr_intr_sched_if.sv - request, thread-state and interrupt bundle
interface thr_intr_sched_if;
    logic       req_valid;
    logic [1:0] req_type;
    logic [1:0] req_thr;
    logic       req_ready;
    logic [4:0] thr_state0;
    logic [4:0] thr_state1;
    logic [4:0] thr_state2;
    logic [4:0] thr_state3;
    logic       nukeint;
    logic       resumint;
    logic       rstint;
    logic [3:0] rstthr;
    logic       busy;
    logic       timeout_err;
    logic [1:0] timeout_thr;

    modport master (
        output req_valid, req_type, req_thr,
        output thr_state0, thr_state1, thr_state2, thr_state3,
        input  req_ready, nukeint, resumint, rstint, rstthr,
        input  busy, timeout_err, timeout_thr
    );

    modport slave (
        input  req_valid, req_type, req_thr,
        input  thr_state0, thr_state1, thr_state2, thr_state3,
        output req_ready, nukeint, resumint, rstint, rstthr,
        output busy, timeout_err, timeout_thr
    );
endinterface

// File: rtl/thr_rr_arb4.sv
// rtl/thr_rr_arb4.sv - 4-way round-robin arbiter with advance-on-grant pointer
module thr_rr_arb4 (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] req,
    input  logic       advance,
    output logic [3:0] gnt,
    output logic [1:0] gnt_idx
);

    logic [1:0] ptr_q;

    // Search starts one past the last granted thread
    always_comb begin
        logic [1:0] idx;
        logic       found;
        gnt     = 4'b0000;
        gnt_idx = 2'd0;
        found   = 1'b0;
        idx     = 2'd0;
        for (int i = 1; i <= 4; i++) begin
            idx = ptr_q + 2'(i);
            if (!found && req[idx]) begin
                gnt[idx] = 1'b1;
                gnt_idx  = idx;
                found    = 1'b1;
            end
        end
    end

    // Pointer resets to thread 3 so the first search begins at thread 0
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q <= 2'd3;
        end else if (advance && (gnt != 4'b0000)) begin
            ptr_q <= gnt_idx;
        end
    end

endmodule

// File: rtl/thr_intr_sched.sv
// rtl/thr_intr_sched.sv - per-thread interrupt scheduler; THR_INTR_TIMEOUT_EN enables completion timeout
module thr_intr_sched
    import thr_intr_pkg::*;
#(
    parameter int unsigned MAX_WAIT = 2000,
    parameter int unsigned GAP_CYC  = 2
) (
    input  logic              clk,
    input  logic              rst,
    thr_intr_sched_if.slave   bus
);

    sched_state_e state_q, state_d;
    logic [3:0]   slot_vld_q;
    req_type_e    slot_type_q [4];
    logic [1:0]   cur_thr_q;
    req_type_e    cur_type_q;
    logic [3:0]   gap_cnt_q;
    logic [4:0]   thr_st [4];

    logic         accept;
    logic         grant_take;
    logic         issue;
    logic         done;
    logic         to_hit;
    logic         to_fire;
    logic [3:0]   arb_gnt;
    logic [1:0]   arb_idx;

    assign thr_st[0] = bus.thr_state0;
    assign thr_st[1] = bus.thr_state1;
    assign thr_st[2] = bus.thr_state2;
    assign thr_st[3] = bus.thr_state3;

    assign bus.req_ready = ~rst & ~slot_vld_q[bus.req_thr];
    assign accept        = bus.req_valid & ~slot_vld_q[bus.req_thr];
    assign done          = (state_q == ST_WAIT) && req_done(cur_type_q, thr_st[cur_thr_q]);

    thr_rr_arb4 u_arb (
        .clk     (clk),
        .rst     (rst),
        .req     (slot_vld_q),
        .advance (grant_take),
        .gnt     (arb_gnt),
        .gnt_idx (arb_idx)
    );

`ifdef THR_INTR_TIMEOUT_EN
    logic [15:0] wait_cnt_q;
    logic [1:0]  timeout_thr_q;

    assign to_hit = (wait_cnt_q == 16'(MAX_WAIT));

    // Wait counter: cleared on issue, counts unfinished WAIT cycles, saturates
    always_ff @(posedge clk) begin
        if (rst) begin
            wait_cnt_q <= 16'd0;
        end else if (state_q == ST_ISSUE) begin
            wait_cnt_q <= 16'd0;
        end else if ((state_q == ST_WAIT) && !done && (wait_cnt_q != 16'hFFFF)) begin
            wait_cnt_q <= wait_cnt_q + 16'd1;
        end
    end

    // Remember which thread timed out until the next timeout
    always_ff @(posedge clk) begin
        if (rst) begin
            timeout_thr_q <= 2'd0;
        end else if (to_fire) begin
            timeout_thr_q <= cur_thr_q;
        end
    end

    assign bus.timeout_err = ~rst & to_fire;
    assign bus.timeout_thr = rst ? 2'd0 : timeout_thr_q;
`else
    assign to_hit          = 1'b0;
    assign bus.timeout_err = 1'b0;
    assign bus.timeout_thr = 2'd0;
`endif

    // Pending slots: type 3 is swallowed, a full slot is never overwritten
    always_ff @(posedge clk) begin
        if (rst) begin
            slot_vld_q <= 4'b0000;
            for (int i = 0; i < 4; i++) begin
                slot_type_q[i] <= REQ_NUKE;
            end
        end else begin
            if (issue) begin
                slot_vld_q[cur_thr_q] <= 1'b0;
            end
            if (accept && (req_type_e'(bus.req_type) != REQ_RSVD)) begin
                slot_vld_q[bus.req_thr]  <= 1'b1;
                slot_type_q[bus.req_thr] <= req_type_e'(bus.req_type);
            end
        end
    end

    // Scheduler state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: arbitrate, pulse, wait for the thread to react, then back off
    always_comb begin
        state_d    = state_q;
        grant_take = 1'b0;
        issue      = 1'b0;
        to_fire    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (slot_vld_q != 4'b0000) begin
                    grant_take = 1'b1;
                    state_d    = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                issue   = 1'b1;
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (done) begin
                    state_d = (GAP_CYC == 0) ? ST_IDLE : ST_GAP;
                end else if (to_hit) begin
                    to_fire = 1'b1;
                    state_d = (GAP_CYC == 0) ? ST_IDLE : ST_GAP;
                end
            end
            ST_GAP: begin
                if (gap_cnt_q == 4'(GAP_CYC - 1)) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Capture the granted request and count gap cycles
    always_ff @(posedge clk) begin
        if (rst) begin
            cur_thr_q  <= 2'd0;
            cur_type_q <= REQ_NUKE;
            gap_cnt_q  <= 4'd0;
        end else begin
            if (grant_take) begin
                cur_thr_q  <= arb_idx;
                cur_type_q <= slot_type_q[arb_idx];
            end
            if (state_q == ST_GAP) begin
                gap_cnt_q <= gap_cnt_q + 4'd1;
            end else begin
                gap_cnt_q <= 4'd0;
            end
        end
    end

    assign bus.nukeint  = ~rst & (state_q == ST_ISSUE) & (cur_type_q == REQ_NUKE);
    assign bus.resumint = ~rst & (state_q == ST_ISSUE) & (cur_type_q == REQ_RESUME);
    assign bus.rstint   = ~rst & (state_q == ST_ISSUE) & (cur_type_q == REQ_RESET);
    assign bus.rstthr   = (~rst & (state_q == ST_ISSUE)) ? (4'b0001 << cur_thr_q) : 4'b0000;
    assign bus.busy     = ~rst & ((slot_vld_q != 4'b0000) | (state_q != ST_IDLE));

endmodule
